// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit: cache-miss FSM states,
// the load result-source encoding and the forwarding mux select encodings.
package hazard_control_unit_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned FWD_W   = 2;

    localparam logic [SRC_W-1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MISS   = 2'd1,
        ST_RESUME = 2'd2
    } miss_state_e;

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// ALU operand forwarding select for one execute-stage source register.
module forward_select
    import hazard_control_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [FWD_W-1:0] fwd_c
);

    // Memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        fwd_c = FWD_NONE;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd_c = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: operand forwarding, load-use stall, branch flush,
// data-cache miss freeze FSM and a stall-cycle performance counter.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [SRC_W-1:0] ResultSrcE,
    input  logic             PCSrcE,
    input  logic             CacheMissM,
    input  logic             CacheReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [FWD_W-1:0] ForwardAE,
    output logic [FWD_W-1:0] ForwardBE,
    output logic [CNT_W-1:0] StallCycles
);

    miss_state_e state, next_state;
    logic        freeze;
    logic        lw_stall;

    forward_select u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_c       (ForwardAE)
    );

    forward_select u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_c       (ForwardBE)
    );

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Freeze starts in the same cycle the miss is first seen in IDLE.
    always_comb begin
        next_state = state;
        freeze     = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        StallW     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (CacheMissM) begin
                    freeze     = 1'b1;
                    next_state = ST_MISS;
                end
            end
            ST_MISS: begin
                freeze = 1'b1;
                if (CacheReadyM) begin
                    next_state = ST_RESUME;
                end
            end
            ST_RESUME: begin
                freeze     = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= '0;
        end else if (StallF) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: spec-level model checked every cycle
// plus literal expectations at key points.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, CacheMissM, CacheReadyM;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCycles;

    int vectors     = 0;
    int miscompares = 0;

    bit          check_en = 1'b0;
    bit          m_in_miss;
    bit          m_resume;
    logic [31:0] m_cnt;

    hazard_control_unit dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .CacheMissM(CacheMissM), .CacheReadyM(CacheReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_freeze();
        return m_in_miss || m_resume || CacheMissM;
    endfunction

    function automatic bit exp_lw();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic bit exp_stallf();
        return exp_freeze() || (!PCSrcE && exp_lw());
    endfunction

    // Spec-level model: miss in progress / one resume cycle pending, counter.
    always @(posedge clk) begin
        if (rst) begin
            m_in_miss <= 1'b0;
            m_resume  <= 1'b0;
            m_cnt     <= 32'd0;
        end else begin
            m_cnt <= m_cnt + 32'(exp_stallf());
            if (m_resume) begin
                m_resume <= 1'b0;
            end else if (m_in_miss) begin
                if (CacheReadyM) begin
                    m_in_miss <= 1'b0;
                    m_resume  <= 1'b1;
                end
            end else if (CacheMissM) begin
                m_in_miss <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit fz, lw;
            fz = exp_freeze();
            lw = exp_lw();
            chk("m_StallF", 32'(StallF), 32'(exp_stallf()));
            chk("m_StallD", 32'(StallD), 32'(exp_stallf()));
            chk("m_StallE", 32'(StallE), 32'(fz));
            chk("m_StallM", 32'(StallM), 32'(fz));
            chk("m_StallW", 32'(StallW), 32'(fz));
            chk("m_FlushD", 32'(FlushD), 32'(!fz && PCSrcE));
            chk("m_FlushE", 32'(FlushE), 32'(!fz && (PCSrcE || lw)));
            chk("m_ForwardAE", 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
            chk("m_ForwardBE", 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
            chk("m_StallCycles", StallCycles, m_cnt);
        end
    end

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
        CacheMissM = 0; CacheReadyM = 0;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        check_en = 1'b1;

        // Post-reset state with all inputs idle
        sample();
        chk("rst_stalls", {27'd0, StallF, StallD, StallE, StallM, StallW}, 32'd0);
        chk("rst_flush", {30'd0, FlushD, FlushE}, 32'd0);
        chk("rst_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        chk("rst_cnt", StallCycles, 32'd0);
        next_cycle();

        // Forwarding priority and zero-register guard
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        sample();
        chk("fwd_m_wins", 32'(ForwardAE), 32'd2);
        RdM = 0;
        #1;
        chk("fwd_w", 32'(ForwardAE), 32'd1);
        next_cycle();
        RdW = 9; Rs2E = 9; RdM = 9; RegWriteM = 0;
        sample();
        chk("fwd_b_w", 32'(ForwardBE), 32'd1);
        next_cycle();
        RdW = 0; Rs2E = 0; RegWriteW = 1;
        sample();
        chk("fwd_zero", 32'(ForwardBE), 32'd0);
        next_cycle();
        clear_inputs();

        // Load-use for one cycle
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        sample();
        chk("lw_stallf", 32'(StallF), 32'd1);
        chk("lw_flushe", 32'(FlushE), 32'd1);
        chk("lw_flushd", 32'(FlushD), 32'd0);
        next_cycle();
        clear_inputs();
        sample();
        chk("lw_cnt", StallCycles, 32'd1);
        next_cycle();

        // Load with rd=x0 does not stall
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        sample();
        chk("lw_x0", 32'(StallF), 32'd0);
        next_cycle();

        // Branch beats simultaneous load-use
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1;
        sample();
        chk("br_flush", {30'd0, FlushD, FlushE}, 32'd3);
        chk("br_stall", {30'd0, StallF, StallD}, 32'd0);
        next_cycle();
        clear_inputs();

        // Ready pulse in IDLE is ignored
        CacheReadyM = 1;
        sample();
        chk("rdy_idle", 32'(StallF), 32'd0);
        next_cycle();
        clear_inputs();

        // Miss at cycle 0, ready at cycle 4; freeze overrides branch and load-use
        for (int k = 0; k <= 6; k++) begin
            CacheMissM  = (k <= 4);
            CacheReadyM = (k == 4);
            PCSrcE      = (k == 2);
            ResultSrcE  = (k == 3) ? 2'b01 : 2'b00;
            RdE = 4; Rs1D = 4;
            sample();
            if (k <= 5) begin
                chk("miss_stallw", 32'(StallW), 32'd1);
                chk("miss_flushd", 32'(FlushD), 32'd0);
            end else begin
                chk("miss_done", 32'(StallF), 32'd0);
                chk("miss_cnt", StallCycles, 32'd7);
            end
            next_cycle();
        end
        clear_inputs();

        // Miss held through RESUME: not re-entered there, re-entered from IDLE
        for (int k = 0; k <= 5; k++) begin
            CacheMissM  = (k <= 3);
            CacheReadyM = (k == 1) || (k == 2) || (k == 5);
            sample();
            next_cycle();
        end
        clear_inputs();
        repeat (2) next_cycle();

        // Reset at cycle 2 of a miss abandons it
        CacheMissM = 1;
        next_cycle();
        next_cycle();
        CacheMissM = 0; rst = 1;
        sample();
        chk("rst_mid_stall", 32'(StallF), 32'd1);
        next_cycle();
        rst = 0;
        sample();
        chk("rst_mid_idle", 32'(StallF), 32'd0);
        chk("rst_mid_cnt", StallCycles, 32'd0);
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk, input, 1, rising-edge clock.
REQ-002 rst SHALL be an input, 1 bit, synchronous active-high reset.
REQ-003 Rs1D, Rs2D SHALL be inputs, 5 bits each, decode-stage source registers.
REQ-004 Rs1E, Rs2E, RdE SHALL be inputs, 5 bits each, execute-stage register indices.
REQ-005 RdM, RdW SHALL be inputs, 5 bits each, memory- and writeback-stage destinations.
REQ-006 RegWriteM, RegWriteW SHALL be inputs, 1 bit each, write enables of the M and W stages.
REQ-007 ResultSrcE SHALL be an input, 2 bits; the value 2'b01 marks a load in E.
REQ-008 PCSrcE SHALL be an input, 1 bit, meaning a branch or jump is taken in E.
REQ-009 CacheMissM and CacheReadyM SHALL be inputs, 1 bit each: a data-cache miss in M, and the refill-complete pulse.
REQ-010 StallF, StallD, StallE, StallM, StallW SHALL be outputs, 1 bit each; each stage register's en equals the inverse of its stall.
REQ-011 FlushD and FlushE SHALL be outputs, 1 bit each, ORed into rst of the F->D and D->E registers.
REQ-012 ForwardAE and ForwardBE SHALL be outputs, 2 bits each, ALU operand mux selects.
REQ-013 StallCycles SHALL be an output, 32 bits, a performance counter.

Function
REQ-014 Forwarding SHALL follow these rules for ForwardAE (Rs1E): 2'b10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 2'b01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 2'b00.
REQ-015 ForwardBE SHALL use the same rules on Rs2E; M always wins over W.
REQ-016 lwStall SHALL be (ResultSrcE==2'b01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-017 The FSM SHALL have three states: IDLE, MISS and RESUME.
REQ-018 IDLE SHALL go to MISS when CacheMissM=1.
REQ-019 MISS SHALL go to RESUME when CacheReadyM=1.
REQ-020 RESUME SHALL go to IDLE unconditionally after 1 cycle.
REQ-021 MISS SHALL also be entered on the same edge CacheMissM is first seen: freeze is asserted combinationally in IDLE whenever CacheMissM=1.
REQ-022 Freeze SHALL be asserted while state is MISS or RESUME, or while in IDLE with CacheMissM=1.
REQ-023 During freeze, all five Stall outputs SHALL be 1 and FlushD=FlushE=0; lwStall and PCSrcE are ignored.
REQ-024 Outside freeze, with PCSrcE=1: FlushD=1, FlushE=1, StallF=StallD=0; the branch has priority over a simultaneous lwStall.
REQ-025 Outside freeze, with lwStall=1 and PCSrcE=0: StallF=1, StallD=1, FlushE=1, FlushD=0.
REQ-026 Outside freeze, StallE, StallM and StallW SHALL be 0.
REQ-027 A CacheReadyM pulse seen in IDLE or RESUME SHALL be ignored.
REQ-028 CacheMissM seen in RESUME SHALL NOT re-enter MISS; back-to-back misses re-enter MISS from IDLE.
REQ-029 StallCycles SHALL increment by 1 on each cycle StallF=1, wrapping modulo 2^32.
REQ-030 The forwarding outputs SHALL be combinational with zero latency.
REQ-031 Stall and flush outputs SHALL be combinational from the current state and inputs.

Reset
REQ-032 While rst=1, the FSM SHALL be forced to IDLE and StallCycles to 0 on the clock edge.
REQ-033 A reset in the middle of MISS SHALL abandon the miss, with no RESUME cycle.
REQ-034 Outputs in the cycle after reset, with all inputs 0, SHALL be: all Stall 0, all Flush 0, Forward 2'b00, StallCycles 0.

Structure
REQ-035 The FSM state enum, the load encoding 2'b01 and the forward encodings (00/01/10) SHALL live in the shared pipeline package.
REQ-036 The forwarding logic SHALL be one sub-module, forward_select, instantiated twice (operands A and B); the FSM and counter stay in the top.

Verification
REQ-037 Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10; with RdM=0 -> 2'b01.
REQ-038 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; StallCycles increments by 1.
REQ-039 Branch plus load-use in the same cycle -> FlushD=FlushE=1 and StallF=StallD=0.
REQ-040 Miss: CacheMissM=1 at cycle 0, CacheReadyM at cycle 4 -> all stalls 1 for cycles 0-5, IDLE at cycle 6, StallCycles=6.
REQ-041 rst at cycle 2 of a miss -> state IDLE, StallCycles=0, stalls 0 on the next cycle.
